ccm_frame_scheduler: RTL and testbench

Frame-level controller for the chromatic-adaptation pixel processor. It fetches sRGB pixels from the source frame buffer and issues them one at a time to the processor over a valid/ready handshake. It writes each corrected pixel to the destination frame buffer. It also owns the processor's matrix_valid qualifier and applies new Bradford compensation matrices only between frames, never mid-frame.

---
 rtl/ccm_pkg.sv | 34 +++
 rtl/ccm_timeout_counter.sv | 41 ++++
 rtl/ccm_frame_scheduler.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ccm_frame_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ccm_pkg                                                    |
// | Description : Shared types and constants for the chromatic-adaptation    |
// |               frame scheduler and its pixel processor.                   |
// | Contents    : state_e  - frame scheduler states                          |
// |               PIX_W    - packed sRGB pixel width                         |
// |               Q_*      - Q16.16 fixed-point constants for the matrices   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package ccm_pkg;

   localparam int PIX_W = 24;

   // Q16.16 format used by the processor's Bradford matrix coefficients.
   localparam int Q_W         = 32;
   localparam int Q_FRAC_BITS = 16;
   localparam logic signed [Q_W-1:0] Q_ONE  = 32'sh0001_0000;
   localparam logic signed [Q_W-1:0] Q_ZERO = 32'sh0000_0000;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      SWAP     = 4'd1,
      FETCH    = 4'd2,
      WAIT_RD  = 4'd3,
      ISSUE    = 4'd4,
      WAIT_RES = 4'd5,
      WRITE    = 4'd6,
      DONE     = 4'd7,
      DRAIN    = 4'd8
   } state_e;

endpackage : ccm_pkg
`default_nettype wire

// File: rtl/ccm_timeout_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ccm_timeout_counter                                        |
// | Description : Saturating watchdog for an outstanding processor result.   |
// |               Counts enabled cycles from a clear; expired_o is high      |
// |               while enabled on the TIMEOUT-th cycle after the clear.     |
// | Ports       : clk, rst_n (async, active low)                             |
// |               clear_i   - restart the count from zero                    |
// |               enable_i  - count this cycle                               |
// |               expired_o - count has reached TIMEOUT-1                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ccm_timeout_counter #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (enable_i && !expired_o) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired_o = enable_i && (cnt_q == LIMIT);

endmodule : ccm_timeout_counter
`default_nettype wire

// File: rtl/ccm_frame_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ccm_frame_scheduler                                        |
// | Description : Streams one frame from the source buffer through the       |
// |               chromatic-adaptation processor into the destination        |
// |               buffer, one pixel outstanding at a time. Owns the          |
// |               processor's matrix_valid qualifier and only swaps in a new |
// |               matrix between frames.                                     |
// | Ports       : clk, rst_n (async, active low)                             |
// |               start_i / abort_i / mat_update_i - control pulses          |
// |               mat_load_o, proc_mat_valid_o     - matrix register ctrl    |
// |               rd_en_o, rd_addr_o, rd_data_i    - source buffer           |
// |               proc_*                           - processor input hs      |
// |               res_rgb_i, res_valid_i           - processor result        |
// |               wr_en_o, wr_addr_o, wr_data_o    - destination buffer      |
// |               cur_line_o, busy_o, frame_done_o, err_o - status           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ccm_frame_scheduler
   import ccm_pkg::*;
#(
   parameter int H_RES   = 800,
   parameter int V_RES   = 480,
   parameter int ADDR_W  = 19,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              mat_update_i,
   output logic              mat_load_o,
   output logic              proc_mat_valid_o,
   output logic              rd_en_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [PIX_W-1:0]  rd_data_i,
   output logic [PIX_W-1:0]  proc_rgb_o,
   output logic              proc_valid_o,
   input  logic              proc_ready_i,
   input  logic [PIX_W-1:0]  res_rgb_i,
   input  logic              res_valid_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [PIX_W-1:0]  wr_data_o,
   output logic [9:0]        cur_line_o,
   output logic              busy_o,
   output logic              frame_done_o,
   output logic              err_o
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
   localparam int                COL_W     = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_RES - 1);

   state_e            state_q;
   logic              mat_pending_q;
   logic              proc_mat_valid_q;
   logic              mat_load_q;
   logic              rd_en_q;
   logic              proc_valid_q;
   logic              wr_en_q;
   logic              busy_q;
   logic              frame_done_q;
   logic              err_q;
   logic              res_seen_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [PIX_W-1:0]  pix_q;
   logic [PIX_W-1:0]  wr_data_q;
   logic [COL_W-1:0]  col_q;
   logic [9:0]        line_q;

   logic              tmo_clear;
   logic              tmo_enable;
   logic              tmo_expired;
   logic [ADDR_W-1:0] addr_nxt;

   // The watchdog starts on the accepted handshake and keeps running into
   // DRAIN so an abort never extends the total wait for a lost result.
   assign tmo_clear  = (state_q == ISSUE) && proc_ready_i;
   assign tmo_enable = (state_q == WAIT_RES) || (state_q == DRAIN);
   assign addr_nxt   = addr_q + 1'b1;

   ccm_timeout_counter #(
      .TIMEOUT   (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (tmo_clear),
      .enable_i  (tmo_enable),
      .expired_o (tmo_expired)
   );

   // Outputs are registered: each strobe/qualifier is set on the transition
   // into the state that owns it, so it is valid for exactly that state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         mat_pending_q    <= 1'b0;
         proc_mat_valid_q <= 1'b0;
         mat_load_q       <= 1'b0;
         rd_en_q          <= 1'b0;
         proc_valid_q     <= 1'b0;
         wr_en_q          <= 1'b0;
         busy_q           <= 1'b0;
         frame_done_q     <= 1'b0;
         err_q            <= 1'b0;
         res_seen_q       <= 1'b0;
         addr_q           <= '0;
         rd_addr_q        <= '0;
         wr_addr_q        <= '0;
         pix_q            <= '0;
         wr_data_q        <= '0;
         col_q            <= '0;
         line_q           <= '0;
      end else begin
         mat_load_q   <= 1'b0;
         rd_en_q      <= 1'b0;
         wr_en_q      <= 1'b0;
         frame_done_q <= 1'b0;

         if (mat_update_i) begin
            mat_pending_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (mat_pending_q) begin
                  // Later assignment wins: entering SWAP consumes the request.
                  mat_pending_q <= 1'b0;
                  mat_load_q    <= 1'b1;
                  busy_q        <= 1'b1;
                  state_q       <= SWAP;
               end else if (start_i) begin
                  if (proc_mat_valid_q) begin
                     err_q     <= 1'b0;
                     addr_q    <= '0;
                     col_q     <= '0;
                     line_q    <= '0;
                     rd_addr_q <= '0;
                     rd_en_q   <= 1'b1;
                     busy_q    <= 1'b1;
                     state_q   <= FETCH;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end

            SWAP: begin
               proc_mat_valid_q <= 1'b1;
               busy_q           <= 1'b0;
               state_q          <= IDLE;
            end

            FETCH: begin
               if (abort_i) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  state_q <= WAIT_RD;
               end
            end

            WAIT_RD: begin
               if (abort_i) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  pix_q        <= rd_data_i;
                  proc_valid_q <= 1'b1;
                  state_q      <= ISSUE;
               end
            end

            ISSUE: begin
               if (proc_ready_i) begin
                  proc_valid_q <= 1'b0;
                  // An abort on the accepting cycle still leaves a result in
                  // flight, so it must be drained rather than dropped.
                  res_seen_q   <= 1'b0;
                  state_q      <= abort_i ? DRAIN : WAIT_RES;
               end else if (abort_i) begin
                  proc_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
                  state_q      <= IDLE;
               end
            end

            WAIT_RES: begin
               if (abort_i) begin
                  // Remember a result arriving with the abort so DRAIN can
                  // leave on its first cycle.
                  res_seen_q <= res_valid_i;
                  state_q    <= DRAIN;
               end else if (res_valid_i) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= addr_q;
                  wr_data_q <= res_rgb_i;
                  state_q   <= WRITE;
               end else if (tmo_expired) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end

            DRAIN: begin
               if (res_seen_q || res_valid_i || tmo_expired) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end

            WRITE: begin
               if (abort_i) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (addr_q == LAST_ADDR) begin
                  frame_done_q <= 1'b1;
                  state_q      <= DONE;
               end else begin
                  addr_q    <= addr_nxt;
                  rd_addr_q <= addr_nxt;
                  rd_en_q   <= 1'b1;
                  state_q   <= FETCH;
                  if (col_q == COL_LAST) begin
                     col_q  <= '0;
                     line_q <= line_q + 10'd1;
                  end else begin
                     col_q <= col_q + 1'b1;
                  end
               end
            end

            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end

            default: begin
               proc_valid_q <= 1'b0;
               busy_q       <= 1'b0;
               state_q      <= IDLE;
            end
         endcase
      end
   end

   assign mat_load_o       = mat_load_q;
   assign proc_mat_valid_o = proc_mat_valid_q;
   assign rd_en_o          = rd_en_q;
   assign rd_addr_o        = rd_addr_q;
   assign proc_rgb_o       = pix_q;
   assign proc_valid_o     = proc_valid_q;
   assign wr_en_o          = wr_en_q;
   assign wr_addr_o        = wr_addr_q;
   assign wr_data_o        = wr_data_q;
   assign cur_line_o       = line_q;
   assign busy_o           = busy_q;
   assign frame_done_o     = frame_done_q;
   assign err_o            = err_q;

endmodule : ccm_frame_scheduler
`default_nettype wire

// File: tb/tb_ccm_frame_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ccm_frame_scheduler                                     |
// | Description : Directed self-checking bench for ccm_frame_scheduler on a  |
// |               4x2 frame with a 5-cycle inverting processor model.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ccm_frame_scheduler;

   localparam int H   = 4;
   localparam int V   = 2;
   localparam int AW  = 3;
   localparam int TO  = 64;
   localparam int LAT = 5;

   logic          clk          = 1'b0;
   logic          rst_n        = 1'b0;
   logic          start_i      = 1'b0;
   logic          abort_i      = 1'b0;
   logic          mat_update_i = 1'b0;
   logic          proc_ready_i = 1'b1;
   logic          res_valid_i  = 1'b0;
   logic [23:0]   rd_data_i    = '0;
   logic [23:0]   res_rgb_i    = '0;

   logic          mat_load_o;
   logic          proc_mat_valid_o;
   logic          rd_en_o;
   logic [AW-1:0] rd_addr_o;
   logic [23:0]   proc_rgb_o;
   logic          proc_valid_o;
   logic          wr_en_o;
   logic [AW-1:0] wr_addr_o;
   logic [23:0]   wr_data_o;
   logic [9:0]    cur_line_o;
   logic          busy_o;
   logic          frame_done_o;
   logic          err_o;

   // Source frame and its hand-inverted destination image.
   logic [23:0] src     [8] = '{24'h000000, 24'h123456, 24'hABCDEF, 24'hFF0000,
                                24'h00FF00, 24'h0000FF, 24'h808080, 24'h5A5AA5};
   logic [23:0] exp_pix [8] = '{24'hFFFFFF, 24'hEDCBA9, 24'h543210, 24'h00FFFF,
                                24'hFF00FF, 24'hFFFF00, 24'h7F7F7F, 24'hA5A55A};

   int n_chk  = 0;
   int n_fail = 0;

   ccm_frame_scheduler #(
      .H_RES   (H),
      .V_RES   (V),
      .ADDR_W  (AW),
      .TIMEOUT (TO)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start_i          (start_i),
      .abort_i          (abort_i),
      .mat_update_i     (mat_update_i),
      .mat_load_o       (mat_load_o),
      .proc_mat_valid_o (proc_mat_valid_o),
      .rd_en_o          (rd_en_o),
      .rd_addr_o        (rd_addr_o),
      .rd_data_i        (rd_data_i),
      .proc_rgb_o       (proc_rgb_o),
      .proc_valid_o     (proc_valid_o),
      .proc_ready_i     (proc_ready_i),
      .res_rgb_i        (res_rgb_i),
      .res_valid_i      (res_valid_i),
      .wr_en_o          (wr_en_o),
      .wr_addr_o        (wr_addr_o),
      .wr_data_o        (wr_data_o),
      .cur_line_o       (cur_line_o),
      .busy_o           (busy_o),
      .frame_done_o     (frame_done_o),
      .err_o            (err_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Source buffer: data one cycle after the read strobe.
   always @(posedge clk) begin
      if (rd_en_o) rd_data_i <= src[rd_addr_o];
   end

   // Processor: result = input ^ FFFFFF, LAT cycles after the handshake.
   int          lat_cnt  = 0;
   logic [23:0] held     = '0;
   logic        withhold = 1'b0;
   always @(posedge clk) begin
      res_valid_i <= 1'b0;
      if (lat_cnt > 0) begin
         lat_cnt <= lat_cnt - 1;
         if (lat_cnt == 1) begin
            res_valid_i <= 1'b1;
            res_rgb_i   <= held;
         end
      end
      if (proc_valid_o && proc_ready_i && !withhold) begin
         lat_cnt <= LAT;
         held    <= proc_rgb_o ^ 24'hFFFFFF;
      end
   end

   // Monitors sample on the falling edge.
   logic [AW-1:0] wr_addr_log [64];
   logic [23:0]   wr_data_log [64];
   logic [9:0]    wr_line_log [64];
   int   wr_cnt = 0, rd_cnt = 0, ml_cnt = 0, fd_cnt = 0;
   int   last_ml_cyc = 0, last_fd_cyc = 0, last_res_cyc = 0;
   int   last_idle_cyc = 0, last_err_cyc = 0;
   logic busy_prev = 1'b0, err_prev = 1'b0;

   always @(negedge clk) begin
      busy_prev <= busy_o;
      err_prev  <= err_o;
      if (wr_en_o) begin
         if (wr_cnt < 64) begin
            wr_addr_log[wr_cnt] <= wr_addr_o;
            wr_data_log[wr_cnt] <= wr_data_o;
            wr_line_log[wr_cnt] <= cur_line_o;
         end
         wr_cnt <= wr_cnt + 1;
      end
      if (rd_en_o) rd_cnt <= rd_cnt + 1;
      if (mat_load_o) begin
         ml_cnt      <= ml_cnt + 1;
         last_ml_cyc <= cyc;
      end
      if (frame_done_o) begin
         fd_cnt      <= fd_cnt + 1;
         last_fd_cyc <= cyc;
      end
      if (res_valid_i) last_res_cyc <= cyc;
      if (busy_prev && !busy_o) last_idle_cyc <= cyc;
      if (err_o && !err_prev) last_err_cyc <= cyc;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic pulse_mat_update();
      mat_update_i = 1'b1;
      @(negedge clk);
      mat_update_i = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while (busy_o && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(busy_o), 0);
   endtask

   task automatic check_frame(input int base, input string tag);
      for (int i = 0; i < H * V; i++) begin
         chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_log[base + i]), i);
         chk($sformatf("%s_data%0d", tag, i), 32'(wr_data_log[base + i]), 32'(exp_pix[i]));
         chk($sformatf("%s_line%0d", tag, i), 32'(wr_line_log[base + i]), (i >= H) ? 1 : 0);
      end
   endtask

   initial begin
      int wb, rd0, ml0, fd0, h, n, rdx;
      logic stable;

      // Reset
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_busy",      32'(busy_o), 0);
      chk("rst_pmv",       32'(proc_mat_valid_o), 0);
      chk("rst_mat_load",  32'(mat_load_o), 0);
      chk("rst_rd_en",     32'(rd_en_o), 0);
      chk("rst_proc_valid",32'(proc_valid_o), 0);
      chk("rst_wr_en",     32'(wr_en_o), 0);
      chk("rst_err",       32'(err_o), 0);
      chk("rst_line",      32'(cur_line_o), 0);

      // Start with no matrix ever loaded
      rd0 = rd_cnt;
      pulse_start();
      chk("nomat_err",  32'(err_o), 1);
      chk("nomat_busy", 32'(busy_o), 0);
      repeat (3) @(negedge clk);
      chk("nomat_no_rd", 32'(rd_cnt - rd0), 0);

      // Matrix load, then a full frame
      ml0 = ml_cnt;
      pulse_mat_update();
      n = 0;
      while (!proc_mat_valid_o && n < 10) begin @(negedge clk); n++; end
      chk("swap_pmv", 32'(proc_mat_valid_o), 1);
      @(negedge clk);
      chk("swap_one_load", 32'(ml_cnt - ml0), 1);
      chk("swap_err_kept", 32'(err_o), 1);
      wb = wr_cnt; fd0 = fd_cnt;
      pulse_start();
      chk("f1_err_clr", 32'(err_o), 0);
      chk("f1_busy",    32'(busy_o), 1);
      wait_idle(300, "f1_idle");
      @(negedge clk);
      chk("f1_writes", 32'(wr_cnt - wb), 8);
      chk("f1_done",   32'(fd_cnt - fd0), 1);
      check_frame(wb, "f1");

      // Matrix update during pixel 3 waits for the frame to finish; a start
      // arriving in SWAP is dropped.
      wb = wr_cnt; fd0 = fd_cnt; ml0 = ml_cnt;
      pulse_start();
      n = 0;
      while (!(rd_en_o && rd_addr_o == 3'd3) && n < 100) begin @(negedge clk); n++; end
      chk("mu_fetch3_seen", 32'(rd_en_o && rd_addr_o == 3'd3), 1);
      pulse_mat_update();
      n = 0;
      while (!frame_done_o && n < 200) begin @(negedge clk); n++; end
      chk("mu_done_seen", 32'(frame_done_o), 1);
      n = 0;
      while (!mat_load_o && n < 10) begin @(negedge clk); n++; end
      chk("mu_load_seen", 32'(mat_load_o), 1);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      rdx = rd_cnt;
      repeat (4) @(negedge clk);
      chk("mu_start_dropped_busy", 32'(busy_o), 0);
      chk("mu_start_dropped_rd",   32'(rd_cnt - rdx), 0);
      chk("mu_one_load",           32'(ml_cnt - ml0), 1);
      chk("mu_load_after_done",    32'(last_ml_cyc > last_fd_cyc), 1);
      chk("mu_writes",             32'(wr_cnt - wb), 8);
      chk("mu_done",               32'(fd_cnt - fd0), 1);
      check_frame(wb, "f2");

      // Abort while waiting for pixel 2's result
      wb = wr_cnt; fd0 = fd_cnt;
      pulse_start();
      n = 0;
      while (!(proc_valid_o && proc_ready_i && rd_addr_o == 3'd2) && n < 100) begin
         @(negedge clk); n++;
      end
      chk("ab_hs2_seen", 32'(proc_valid_o && rd_addr_o == 3'd2), 1);
      @(negedge clk);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      wait_idle(100, "ab_idle");
      repeat (2) @(negedge clk);
      chk("ab_writes",     32'(wr_cnt - wb), 2);
      chk("ab_last_addr",  32'(wr_addr_log[wb + 1]), 1);
      chk("ab_no_done",    32'(fd_cnt - fd0), 0);
      chk("ab_no_err",     32'(err_o), 0);
      chk("ab_idle_after_res", 32'(last_idle_cyc - last_res_cyc), 1);

      // Withheld result: err exactly TO cycles after the handshake edge
      withhold = 1'b1;
      wb = wr_cnt;
      pulse_start();
      n = 0;
      while (!(proc_valid_o && proc_ready_i) && n < 20) begin @(negedge clk); n++; end
      chk("to_hs_seen", 32'(proc_valid_o), 1);
      h = cyc;
      wait_idle(100, "to_idle");
      repeat (2) @(negedge clk);
      chk("to_err",     32'(err_o), 1);
      // handshake edge makes cyc=h+1; err edge is 64 cycles later
      chk("to_latency", 32'(last_err_cyc - h), 65);
      chk("to_no_write", 32'(wr_cnt - wb), 0);
      withhold = 1'b0;

      // Processor stalls pixel 1 for 10 cycles
      wb = wr_cnt; fd0 = fd_cnt;
      pulse_start();
      chk("st_err_clr", 32'(err_o), 0);
      n = 0;
      while (!(rd_en_o && rd_addr_o == 3'd1) && n < 50) begin @(negedge clk); n++; end
      chk("st_fetch1_seen", 32'(rd_en_o), 1);
      proc_ready_i = 1'b0;
      n = 0;
      while (!proc_valid_o && n < 10) begin @(negedge clk); n++; end
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (!proc_valid_o || proc_rgb_o !== 24'h123456) stable = 1'b0;
         @(negedge clk);
      end
      chk("st_stable", 32'(stable), 1);
      proc_ready_i = 1'b1;
      wait_idle(300, "st_idle");
      @(negedge clk);
      chk("st_writes", 32'(wr_cnt - wb), 8);
      chk("st_done",   32'(fd_cnt - fd0), 1);
      check_frame(wb, "f3");

      // Asynchronous reset mid-frame drops the matrix
      pulse_start();
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy",  32'(busy_o), 0);
      chk("arst_pmv",   32'(proc_mat_valid_o), 0);
      chk("arst_rd_en", 32'(rd_en_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rd0 = rd_cnt;
      pulse_start();
      chk("arst_needs_matrix", 32'(err_o), 1);
      repeat (3) @(negedge clk);
      chk("arst_no_rd", 32'(rd_cnt - rd0), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule : tb_ccm_frame_scheduler
`default_nettype wire
